// File: rtl/core_biu_mem_arb.sv
// Memory-port arbiter between IFU and LSU: one outstanding transaction, grant locked until accepted.
// Define CORE_BIU_RR_EN for round-robin arbitration; otherwise LSU has fixed priority.
module core_biu_mem_arb #(
    parameter int XLEN    = 32,
    parameter int WMASK_W = XLEN / 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [XLEN-1:0]    ifu_req_addr,
    output logic               ifu_rsp_valid,
    output logic [XLEN-1:0]    ifu_rsp_rdata,
    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic [XLEN-1:0]    lsu_req_addr,
    input  logic               lsu_req_wen,
    input  logic [XLEN-1:0]    lsu_req_wdata,
    input  logic [WMASK_W-1:0] lsu_req_wmask,
    output logic               lsu_rsp_valid,
    output logic [XLEN-1:0]    lsu_rsp_rdata,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [XLEN-1:0]    mem_addr,
    output logic               mem_wen,
    output logic [XLEN-1:0]    mem_wdata,
    output logic [WMASK_W-1:0] mem_wmask,
    input  logic               mem_rsp_valid,
    input  logic [XLEN-1:0]    mem_rsp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    // owner/last_grant/winner/sel encoding: 0 = IFU, 1 = LSU
    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_grant_q, last_grant_d;
    logic   winner;
    logic   sel;
    logic   req_act;

    always_comb begin
        winner = 1'b0;
        if (ifu_req_valid && lsu_req_valid) begin
`ifdef CORE_BIU_RR_EN
            winner = ~last_grant_q;
`else
            winner = 1'b1;
`endif
        end else begin
            winner = lsu_req_valid;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        sel           = owner_q;
        req_act       = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                sel     = winner;
                req_act = ifu_req_valid | lsu_req_valid;
                if (req_act) begin
                    owner_d = winner;
                    if (mem_req_ready) begin
                        last_grant_d = winner;
                        state_d      = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                req_act = 1'b1;
                if (mem_req_ready) begin
                    last_grant_d = owner_q;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    ifu_rsp_valid = ~owner_q;
                    lsu_rsp_valid = owner_q;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // IFU grants never write: write fields are forced to zero unless the LSU holds the port
    always_comb begin
        mem_req_valid = req_act;
        ifu_req_ready = req_act & ~sel & mem_req_ready;
        lsu_req_ready = req_act & sel & mem_req_ready;
        mem_addr      = req_act ? (sel ? lsu_req_addr : ifu_req_addr) : '0;
        mem_wen       = req_act & sel & lsu_req_wen;
        mem_wdata     = (req_act && sel) ? lsu_req_wdata : '0;
        mem_wmask     = (req_act && sel) ? lsu_req_wmask : '0;
        ifu_rsp_rdata = ifu_rsp_valid ? mem_rsp_rdata : '0;
        lsu_rsp_rdata = lsu_rsp_valid ? mem_rsp_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_core_biu_mem_arb.sv
// Directed scoreboard bench for core_biu_mem_arb; arbitration model follows CORE_BIU_RR_EN.
module tb_core_biu_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_req_addr, ifu_rsp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
    logic [3:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_rdata;
    logic [3:0]  mem_wmask;

    typedef struct packed {
        logic        lsu;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic m_last = 1'b0;

    always #5 clk = ~clk;

    core_biu_mem_arb dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic predict();
        if (ifu_req_valid && lsu_req_valid) begin
`ifdef CORE_BIU_RR_EN
            return ~m_last;
`else
            return 1'b1;
`endif
        end
        return lsu_req_valid;
    endfunction

    // Serve one transaction for the predicted winner: ready held low rdy_dly cycles,
    // response rsp_dly cycles after acceptance. Called at posedge+1 with requests driven.
    task automatic serve(input int rdy_dly, input int rsp_dly, input int raise_lsu_at,
                         input logic [31:0] rdata);
        logic        w;
        logic [31:0] ea, ewd;
        logic        ewen;
        logic [3:0]  ewm;
        exp_t        e;
        w    = predict();
        ea   = w ? lsu_req_addr : ifu_req_addr;
        ewen = w ? lsu_req_wen : 1'b0;
        ewd  = w ? lsu_req_wdata : 32'h0;
        ewm  = w ? lsu_req_wmask : 4'h0;
        mem_req_ready = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            if (i == raise_lsu_at) lsu_req_valid = 1'b1;
            @(negedge clk);
            chk("stall_req_valid", {31'b0, mem_req_valid}, 32'd1);
            chk("stall_ifu_ready", {31'b0, ifu_req_ready}, 32'd0);
            chk("stall_lsu_ready", {31'b0, lsu_req_ready}, 32'd0);
            chk("stall_addr", mem_addr, ea);
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("grant_ifu_ready", {31'b0, ifu_req_ready}, {31'b0, ~w});
        chk("grant_lsu_ready", {31'b0, lsu_req_ready}, {31'b0, w});
        chk("grant_addr", mem_addr, ea);
        chk("grant_wen", {31'b0, mem_wen}, {31'b0, ewen});
        chk("grant_wdata", mem_wdata, ewd);
        chk("grant_wmask", {28'b0, mem_wmask}, {28'b0, ewm});
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        if (w) lsu_req_valid = 1'b0;
        else   ifu_req_valid = 1'b0;
        m_last = w;
        for (int i = 1; i < rsp_dly; i++) begin
            @(negedge clk);
            chk("wait_req_valid", {31'b0, mem_req_valid}, 32'd0);
            chk("wait_rsp_valid", {30'b0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rdata;
        sb_q.push_back('{lsu: w, rdata: rdata});
        @(negedge clk);
        chk("rsp_req_valid", {31'b0, mem_req_valid}, 32'd0);
        e = sb_q.pop_front();
        chk("rsp_ifu_valid", {31'b0, ifu_rsp_valid}, {31'b0, ~e.lsu});
        chk("rsp_lsu_valid", {31'b0, lsu_rsp_valid}, {31'b0, e.lsu});
        if (e.lsu) chk("rsp_lsu_rdata", lsu_rsp_rdata, e.rdata);
        else       chk("rsp_ifu_rdata", ifu_rsp_rdata, e.rdata);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_req_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_req_addr = 32'h0; lsu_req_wen = 1'b0;
        lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_readies", {30'b0, ifu_req_ready, lsu_req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'b0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        @(posedge clk); #1;

        // IFU fetch; LSU write fields hold junk to show they are masked off
        lsu_req_wen = 1'b1; lsu_req_wdata = 32'hFFFF_FFFF; lsu_req_wmask = 4'hF;
        ifu_req_addr = 32'h8000_0000; ifu_req_valid = 1'b1;
        serve(0, 1, -1, 32'h0000_0013);

        lsu_req_addr = 32'h8000_0104; lsu_req_wen = 1'b1;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF; lsu_req_valid = 1'b1;
        serve(0, 1, -1, 32'h0000_0011);

        for (int k = 0; k < 4; k++) begin
            ifu_req_addr  = 32'h8000_1000 + k * 4;
            lsu_req_addr  = 32'h8000_2000 + k * 4;
            lsu_req_wen   = k[0];
            lsu_req_wdata = 32'h1234_0000 + k;
            lsu_req_wmask = 4'h3;
            ifu_req_valid = 1'b1;
            lsu_req_valid = 1'b1;
            serve((k == 3) ? 1 : 0, (k == 2) ? 2 : 1, -1, 32'hC0DE_0000 + k);
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
        end

        // IFU stalled in REQ while LSU raises valid in the second cycle
        ifu_req_addr = 32'h8000_0200; ifu_req_valid = 1'b1;
        lsu_req_addr = 32'h8000_0300; lsu_req_wen = 1'b0;
        lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0;
        serve(3, 1, 1, 32'hA5A5_0001);
        serve(0, 1, -1, 32'h5A5A_0002);

        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBAD0_0001;
        repeat (2) begin
            @(negedge clk);
            chk("spur_idle_rsp", {30'b0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        ifu_req_addr = 32'h8000_0400; ifu_req_valid = 1'b1;
        @(negedge clk);
        chk("spur_req_rsp", {30'b0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        serve(0, 1, -1, 32'h0000_0777);

        // reset while WAIT: late response must be dropped
        ifu_req_addr = 32'h8000_0500; ifu_req_valid = 1'b1; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; mem_req_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_last = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBAD0_0002;
        @(negedge clk);
        chk("rst_wait_rsp", {30'b0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        chk("rst_wait_req", {31'b0, mem_req_valid}, 32'd0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;

        ifu_req_addr = 32'h8000_0600; lsu_req_addr = 32'h8000_0700;
        lsu_req_wen = 1'b1; lsu_req_wdata = 32'h0BAD_F00D; lsu_req_wmask = 4'h5;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        serve(0, 1, -1, 32'h0000_0999);
        ifu_req_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
